// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-write store buffer between cpu data port and data memory
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_wmask,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [29:0]      ent_addr [DEPTH];
  logic [3:0]       ent_mask [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;

  logic full, hit, load_req, load_served, push, pop;

  // Word-granular match against every live entry; byte masks are ignored on purpose.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == cpu_addr[31:2])) hit = 1'b1;
    end
  end

  assign full        = (count == FULL_COUNT);
  assign load_req    = cpu_read & ~cpu_write;
  assign load_served = load_req & ~hit & mem_ready;
  assign push        = cpu_write & ~full;
  assign pop         = ~load_served & (count != '0) & mem_ready;
  assign cpu_stall   = (cpu_write & full) | (load_req & (hit | ~mem_ready));
  assign sb_empty    = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: ent_valid alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= cpu_addr[31:2];
      ent_mask[tail] <= cpu_wmask;
      ent_data[tail] <= cpu_wdata;
    end
  end

  always_comb begin
    cpu_rdata = '0;
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (load_served) begin
      mem_addr  = cpu_addr;
      cpu_rdata = mem_rdata;
    end else if (count != '0) begin
      mem_addr  = {ent_addr[head], 2'b00};
      mem_write = 1'b1;
      mem_wmask = ent_mask[head];
      mem_wdata = ent_data[head];
    end
  end

endmodule
